// File: rtl/q2_pkg.sv
// Shared state codes and opcode field layout for the Q2 sequencer.
package q2_pkg;

   // State word s3..s0 as seen by the control decoder
   typedef enum logic [3:0] {
      ST_FETCH    = 4'b0000,
      ST_DEREF    = 4'b0001,
      ST_LOAD     = 4'b0010,
      ST_EXEC     = 4'b0011,
      ST_ALU      = 4'b0100,
      ST_ALU_LAST = 4'b1100
   } q2_state_e;

   // Bit positions of the opcode fields within the O register
   localparam int OPC_O0 = 0;
   localparam int OPC_O1 = 1;
   localparam int OPC_O2 = 2;
   localparam int OPC_W  = 3;

   // Address-phase successor: indirect words detour through DEREF,
   // o2 then separates ALU-class (LOAD) from non-ALU (EXEC) instructions.
   function automatic q2_state_e addr_next(input logic deref_i,
                                           input logic [OPC_W-1:0] opc_i);
      if (deref_i)
         return ST_DEREF;
      else if (opc_i[OPC_O2])
         return ST_EXEC;
      else
         return ST_LOAD;
   endfunction

endpackage

// File: rtl/q2_bit_counter.sv
// ALU bit-step counter: clear/enable, flags the step after which ALU_LAST follows.
module q2_bit_counter
   import q2_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int CW    = $clog2(WIDTH)
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic en,
   output logic term
);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   // Clear wins over enable so LOAD/ALU_LAST always restart from zero
   always_comb begin
      cnt_d = cnt_q;
      if (clr)
         cnt_d = '0;
      else if (en)
         cnt_d = cnt_q + CW'(1);
   end

   // Counter register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         cnt_q <= '0;
      else
         cnt_q <= cnt_d;
   end

   // Completing the ALU step with this count means the next step is the last
   assign term = (cnt_q == CW'(WIDTH - 2));

endmodule

// File: rtl/q2_sequencer.sv
// Q2 instruction sequencer: produces the state word and write strobe for the
// control decoder, gated by front-panel run/step and stretched by mem_ready.
module q2_sequencer
   import q2_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int CW    = $clog2(WIDTH)
) (
   input  logic clk,
   input  logic rst_n,
   input  logic o0,
   input  logic o1,
   input  logic o2,
   input  logic deref,
   input  logic mem_ready,
   input  logic run,
   input  logic step,
   output logic s0,
   output logic s1,
   output logic s2,
   output logic s3,
   output logic ws,
   output logic halted,
   output logic alu_last
);

   q2_state_e        state_q, state_d;
   logic             ws_q, ws_d;
   logic             halted_q, halted_d;
   logic             cnt_clr, cnt_en, cnt_term;
   logic [OPC_W-1:0] opc;
   logic             unused_opc_bits;

   assign opc[OPC_O0] = o0;
   assign opc[OPC_O1] = o1;
   assign opc[OPC_O2] = o2;

   // Only o2 steers sequencing; o0/o1 are decoded elsewhere
   assign unused_opc_bits = opc[OPC_O0] ^ opc[OPC_O1];

   q2_bit_counter #(
      .WIDTH (WIDTH),
      .CW    (CW)
   ) u_bit_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (cnt_clr),
      .en    (cnt_en),
      .term  (cnt_term)
   );

   // Next-state: read phase is one clock, write phase waits for mem_ready,
   // and the run switch is sampled on the edge that lands in FETCH.
   always_comb begin
      state_d  = state_q;
      ws_d     = ws_q;
      halted_d = halted_q;
      cnt_clr  = 1'b0;
      cnt_en   = 1'b0;
      if (halted_q) begin
         // Parked FETCH read phase already counts as served
         if (run || step) begin
            ws_d     = 1'b1;
            halted_d = 1'b0;
         end
      end else if (!ws_q) begin
         ws_d = 1'b1;
      end else if (mem_ready) begin
         ws_d = 1'b0;
         case (state_q)
            ST_FETCH:    state_d = addr_next(deref, opc);
            ST_DEREF:    state_d = addr_next(1'b0, opc);
            ST_LOAD: begin
               state_d = ST_ALU;
               cnt_clr = 1'b1;
            end
            ST_EXEC:     state_d = ST_FETCH;
            ST_ALU: begin
               cnt_en  = 1'b1;
               state_d = cnt_term ? ST_ALU_LAST : ST_ALU;
            end
            ST_ALU_LAST: begin
               state_d = ST_FETCH;
               cnt_clr = 1'b1;
            end
            default: begin
               state_d = ST_FETCH;
               cnt_clr = 1'b1;
            end
         endcase
         if (state_d == ST_FETCH)
            halted_d = ~run;
      end
   end

   // State, phase and halt registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_FETCH;
         ws_q     <= 1'b0;
         halted_q <= 1'b1;
      end else begin
         state_q  <= state_d;
         ws_q     <= ws_d;
         halted_q <= halted_d;
      end
   end

   assign {s3, s2, s1, s0} = state_q;
   assign ws               = ws_q;
   assign halted           = halted_q;
   assign alu_last         = state_q[3];

endmodule

// File: tb/tb_q2_sequencer.sv
// Directed bench for q2_sequencer: WIDTH=8 and WIDTH=2 instances share stimulus.
module tb_q2_sequencer;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic o0 = 1'b0, o1 = 1'b0, o2 = 1'b0, deref = 1'b0;
   logic mem_ready = 1'b1, run = 1'b0, step = 1'b0;

   logic a_s0, a_s1, a_s2, a_s3, a_ws, a_h, a_al;
   logic b_s0, b_s1, b_s2, b_s3, b_ws, b_h, b_al;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   q2_sequencer #(.WIDTH(8)) dut8 (
      .clk(clk), .rst_n(rst_n), .o0(o0), .o1(o1), .o2(o2), .deref(deref),
      .mem_ready(mem_ready), .run(run), .step(step),
      .s0(a_s0), .s1(a_s1), .s2(a_s2), .s3(a_s3), .ws(a_ws),
      .halted(a_h), .alu_last(a_al)
   );

   q2_sequencer #(.WIDTH(2)) dut2 (
      .clk(clk), .rst_n(rst_n), .o0(o0), .o1(o1), .o2(o2), .deref(deref),
      .mem_ready(mem_ready), .run(run), .step(step),
      .s0(b_s0), .s1(b_s1), .s2(b_s2), .s3(b_s3), .ws(b_ws),
      .halted(b_h), .alu_last(b_al)
   );

   localparam logic [3:0] F  = 4'b0000;
   localparam logic [3:0] D  = 4'b0001;
   localparam logic [3:0] L  = 4'b0010;
   localparam logic [3:0] E  = 4'b0011;
   localparam logic [3:0] A  = 4'b0100;
   localparam logic [3:0] AL = 4'b1100;

   typedef struct {
      int         tag;
      logic       w2;
      logic       run, step, o2, deref, mr;
      logic [3:0] s;
      logic       ws, h;
   } vec_t;

   vec_t vq[$];

   function automatic void pv(input int tag, input logic w2, input logic r,
                              input logic st, input logic op2, input logic dr,
                              input logic mr, input logic [3:0] s,
                              input logic ws, input logic h);
      vec_t v;
      v.tag = tag; v.w2 = w2; v.run = r; v.step = st; v.o2 = op2;
      v.deref = dr; v.mr = mr; v.s = s; v.ws = ws; v.h = h;
      vq.push_back(v);
   endfunction

   task automatic chk(input string nm, input int idx, input logic [3:0] es,
                      input logic ews, input logic eh, input logic [3:0] as,
                      input logic aws, input logic ah, input logic aal);
      checks++;
      if ({as, aws, ah, aal} !== {es, ews, eh, es[3]}) begin
         errors++;
         $display("FAIL %s[%0d]: got s=%b ws=%b halted=%b alu_last=%b, want s=%b ws=%b halted=%b alu_last=%b",
                  nm, idx, as, aws, ah, aal, es, ews, eh, es[3]);
      end
   endtask

   task automatic chk_int(input string nm, input int got, input int want);
      checks++;
      if (got != want) begin
         errors++;
         $display("FAIL %s: got %0d, want %0d", nm, got, want);
      end
   endtask

   // Apply rows lo..hi-1: drive, clock, then sample 1 time unit after the edge
   task automatic apply(input int lo, input int hi);
      for (int i = lo; i < hi; i++) begin
         run = vq[i].run; step = vq[i].step; o2 = vq[i].o2;
         deref = vq[i].deref; mem_ready = vq[i].mr;
         @(posedge clk); #1;
         if (vq[i].w2)
            chk($sformatf("w2_t%0d", vq[i].tag), i, vq[i].s, vq[i].ws, vq[i].h,
                {b_s3, b_s2, b_s1, b_s0}, b_ws, b_h, b_al);
         else
            chk($sformatf("w8_t%0d", vq[i].tag), i, vq[i].s, vq[i].ws, vq[i].h,
                {a_s3, a_s2, a_s1, a_s0}, a_ws, a_h, a_al);
      end
   endtask

   initial begin
      int split;
      int alu_n, last_n;
      logic done;

      // t1: step pulse through one ALU instruction, run low
      pv(1, 0, 0, 1, 0, 0, 1, F, 1, 0);
      pv(1, 0, 0, 0, 0, 0, 1, L, 0, 0);
      pv(1, 0, 0, 0, 0, 0, 1, L, 1, 0);
      for (int k = 0; k < 7; k++) begin
         pv(1, 0, 0, 0, 0, 0, 1, A, 0, 0);
         pv(1, 0, 0, 0, 0, 0, 1, A, 1, 0);
      end
      pv(1, 0, 0, 0, 0, 0, 1, AL, 0, 0);
      pv(1, 0, 0, 0, 0, 0, 1, AL, 1, 0);
      pv(1, 0, 0, 0, 0, 0, 1, F, 0, 1);
      pv(1, 0, 0, 0, 0, 0, 1, F, 0, 1);
      // t2: two indirect non-ALU instructions, then halt
      for (int n = 0; n < 2; n++) begin
         pv(2, 0, 1, 0, 1, 1, 1, F, 1, 0);
         pv(2, 0, 1, 0, 1, 1, 1, D, 0, 0);
         pv(2, 0, 1, 0, 1, 1, 1, D, 1, 0);
         pv(2, 0, 1, 0, 1, 1, 1, E, 0, 0);
         pv(2, 0, 1, 0, 1, 1, 1, E, 1, 0);
         pv(2, 0, n == 0, 0, 1, 1, 1, F, 0, n != 0);
      end
      // t3: LOAD stalled by mem_ready (low also during read phase)
      pv(3, 0, 1, 0, 0, 0, 1, F, 1, 0);
      pv(3, 0, 1, 0, 0, 0, 1, L, 0, 0);
      pv(3, 0, 1, 0, 0, 0, 0, L, 1, 0);
      for (int k = 0; k < 5; k++)
         pv(3, 0, 1, 0, 0, 0, 0, L, 1, 0);
      pv(3, 0, 1, 0, 0, 0, 1, A, 0, 0);
      // t4: run dropped in ALU step 3, stray step ignored, halts after
      pv(4, 0, 1, 0, 0, 0, 1, A, 1, 0);
      for (int k = 2; k <= 7; k++) begin
         pv(4, 0, k < 3, 0, 0, 0, 1, A, 0, 0);
         pv(4, 0, k < 3, k == 4, 0, 0, 1, A, 1, 0);
      end
      pv(4, 0, 0, 0, 0, 0, 1, AL, 0, 0);
      pv(4, 0, 0, 1, 0, 0, 0, AL, 1, 0);
      pv(4, 0, 0, 0, 0, 0, 1, F, 0, 1);
      pv(4, 0, 0, 0, 0, 0, 1, F, 0, 1);
      split = vq.size();
      // t6: WIDTH=2 instance, one ALU step then one ALU_LAST step
      pv(6, 1, 0, 1, 0, 0, 1, F, 1, 0);
      pv(6, 1, 0, 0, 0, 0, 1, L, 0, 0);
      pv(6, 1, 0, 0, 0, 0, 1, L, 1, 0);
      pv(6, 1, 0, 0, 0, 0, 1, A, 0, 0);
      pv(6, 1, 0, 0, 0, 0, 1, A, 1, 0);
      pv(6, 1, 0, 0, 0, 0, 1, AL, 0, 0);
      pv(6, 1, 0, 0, 0, 0, 1, AL, 1, 0);
      pv(6, 1, 0, 0, 0, 0, 1, F, 0, 1);
      pv(6, 1, 0, 0, 0, 0, 1, F, 0, 1);

      // Reset state, then 20 halted clocks with run low
      repeat (2) @(posedge clk);
      #1 chk("reset", 0, F, 0, 1, {a_s3, a_s2, a_s1, a_s0}, a_ws, a_h, a_al);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;
      for (int k = 0; k < 20; k++) begin
         @(posedge clk); #1;
         chk("halt_hold", k, F, 0, 1, {a_s3, a_s2, a_s1, a_s0}, a_ws, a_h, a_al);
      end

      apply(0, split);

      // t5: async reset in the middle of a held EXEC write phase
      run = 1'b1; o2 = 1'b1; deref = 1'b0; mem_ready = 1'b1;
      @(posedge clk); #1;
      chk("t5_f", 0, F, 1, 0, {a_s3, a_s2, a_s1, a_s0}, a_ws, a_h, a_al);
      @(posedge clk); #1;
      chk("t5_e0", 0, E, 0, 0, {a_s3, a_s2, a_s1, a_s0}, a_ws, a_h, a_al);
      mem_ready = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk("t5_e1", 0, E, 1, 0, {a_s3, a_s2, a_s1, a_s0}, a_ws, a_h, a_al);
      #3 rst_n = 1'b0;
      #1 chk("t5_async", 0, F, 0, 1, {a_s3, a_s2, a_s1, a_s0}, a_ws, a_h, a_al);
      @(negedge clk) rst_n = 1'b1;
      o2 = 1'b0; mem_ready = 1'b1; run = 1'b1;
      alu_n = 0; last_n = 0; done = 1'b0;
      for (int c = 0; c < 100 && !done; c++) begin
         @(posedge clk); #1;
         if ({a_s3, a_s2, a_s1, a_s0} == A && !a_ws) alu_n++;
         if ({a_s3, a_s2, a_s1, a_s0} == AL && !a_ws) last_n++;
         if (last_n > 0 && {a_s3, a_s2, a_s1, a_s0} == F) done = 1'b1;
      end
      chk_int("t5_done", int'(done), 1);
      chk_int("t5_alu_steps", alu_n, 7);
      chk_int("t5_last_steps", last_n, 1);
      run = 1'b0;
      repeat (40) @(posedge clk);

      // Fresh reset before the WIDTH=2 sequence
      #1 rst_n = 1'b0;
      @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;
      chk("w2_reset", 0, F, 0, 1, {b_s3, b_s2, b_s1, b_s0}, b_ws, b_h, b_al);
      apply(split, vq.size());

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
